// File: rtl/nx1_fifo_ctrl.sv
// nx1_fifo_ctrl
// Runs an external asymmetric Nx1 RAM (wide write port A, narrow read port B,
// 2:1 width ratio) as a width-down FIFO. Wide words come in on a valid/ready
// write interface. Narrow words leave on a valid/ready read interface, lower
// half first, at up to one word per cycle.
//
// Ports
//   clk        single clock; also clocks both RAM ports
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of all state, highest priority
//   wr_valid   write request
//   wr_ready   write can be accepted
//   wr_data    wide word; bits [WIDTHB-1:0] are read out first
//   rd_valid   rd_data holds a word
//   rd_ready   consumer takes rd_data
//   rd_data    narrow output word (head of the output buffer, registered)
//   level      narrow words accepted and not yet popped
//   ram_weA    RAM port A write enable
//   ram_addrA  RAM port A wide address
//   ram_diA    RAM port A write data
//   ram_reB    RAM port B read enable
//   ram_addrB  RAM port B narrow address
//   ram_doB    RAM port B read data, valid one cycle after ram_reB
module nx1_fifo_ctrl #(
  parameter int WIDTHB     = 18,
  parameter int ADDRWIDTHA = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [2*WIDTHB-1:0]     wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [WIDTHB-1:0]       rd_data,
  output logic [ADDRWIDTHA+1:0]   level,
  output logic                    ram_weA,
  output logic [ADDRWIDTHA-1:0]   ram_addrA,
  output logic [2*WIDTHB-1:0]     ram_diA,
  output logic                    ram_reB,
  output logic [ADDRWIDTHA:0]     ram_addrB,
  input  logic [WIDTHB-1:0]       ram_doB
);

  localparam int AW = ADDRWIDTHA;
  localparam int W  = WIDTHB;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW:0]   wp;        // wide write pointer with wrap bit
  logic [AW+1:0] rp;        // narrow read-issue pointer with wrap bit
  logic          inflight;  // a RAM read was issued last cycle
  logic [1:0]    obCnt;
  logic [W-1:0]  ob0;       // head
  logic [W-1:0]  ob1;

  logic [AW:0]   used;
  logic          avail;
  logic          push;
  logic          pop;
  logic          issue;
  logic [2:0]    occ;

  logic [1:0]    obCntNxt;
  logic [W-1:0]  ob0Nxt;
  logic [W-1:0]  ob1Nxt;

  // A wide entry only counts as free once both halves have been issued,
  // hence the comparison against the wide part of the read pointer.
  assign used     = wp - rp[AW+1:1];
  assign wr_ready = (used != DEPTH) && !flush;
  assign push     = wr_valid && wr_ready;

  // Availability looks at registered wp only, so a word written on one edge
  // is read no earlier than the following cycle (no same-address R/W).
  assign avail = ({wp, 1'b0} != rp);
  assign pop   = rd_valid && rd_ready;

  // Output-buffer occupancy after this cycle's pop, counting the read that
  // returns this cycle. obCnt + inflight never exceeds 2 and pop implies
  // obCnt >= 1, so this cannot underflow.
  assign occ   = {1'b0, obCnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue = avail && (occ < 3'd2) && !flush;

  assign ram_weA   = push;
  assign ram_addrA = wp[AW-1:0];
  assign ram_diA   = wr_data;
  assign ram_reB   = issue;
  assign ram_addrB = rp[AW:0];

  assign rd_valid = (obCnt != 2'd0);
  assign rd_data  = ob0;

  assign level = {wp, 1'b0} - rp
               + {{(AW+1){1'b0}}, inflight}
               + {{AW{1'b0}}, obCnt};

  // Pop shifts the buffer first; returning RAM data then lands in the first
  // free slot, so a pop and an append can share a cycle.
  always_comb begin
    ob0Nxt   = ob0;
    ob1Nxt   = ob1;
    obCntNxt = obCnt;
    if (pop) begin
      ob0Nxt   = ob1;
      obCntNxt = obCnt - 2'd1;
    end
    if (inflight) begin
      if (obCntNxt == 2'd0) ob0Nxt = ram_doB;
      else                  ob1Nxt = ram_doB;
      obCntNxt = obCntNxt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      inflight <= 1'b0;
      obCnt    <= 2'd0;
      ob0      <= '0;
      ob1      <= '0;
    end else if (flush) begin
      // Clearing inflight drops any RAM data still on its way back.
      wp       <= '0;
      rp       <= '0;
      inflight <= 1'b0;
      obCnt    <= 2'd0;
    end else begin
      if (push)  wp <= wp + 1'b1;
      if (issue) rp <= rp + 1'b1;
      inflight <= issue;
      obCnt    <= obCntNxt;
      ob0      <= ob0Nxt;
      ob1      <= ob1Nxt;
    end
  end

endmodule
